// File: rtl/reg_share_arbiter.sv
// rtl/reg_share_arbiter.sv - round-robin write-ownership arbiter for one shared register
// Grants one of N requesters at a time, bounds hold time under contention, writes q from the owner lane.
module reg_share_arbiter #(
    parameter int N        = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N-1:0]         req,
    input  logic [N-1:0]         wr_en,
    input  logic [N*WIDTH-1:0]   wdata,
    output logic [N-1:0]         gnt,
    output logic [$clog2(N)-1:0] owner,
    output logic                 busy,
    output logic [WIDTH-1:0]     q,
    output logic                 q_valid
);

    localparam int IW = $clog2(N);
    localparam int HW = $clog2(MAX_HOLD + 1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [N-1:0]      r_gnt;
    logic [N-1:0]      w_gnt_nxt;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     w_owner_nxt;
    logic [IW-1:0]     r_ptr;
    logic [IW-1:0]     w_ptr_nxt;
    logic [HW-1:0]     r_hcnt;
    logic [HW-1:0]     w_hcnt_nxt;
    logic [WIDTH-1:0]  r_q;
    logic              r_q_valid;

    logic [N-1:0]      w_others;
    logic [IW-1:0]     w_win;
    logic              w_do_grant;
    logic              w_wr;
    logic [WIDTH-1:0]  w_lane [N];

    // First set bit of mask, searching upward from start and wrapping modulo N.
    function automatic logic [IW-1:0] rr_pick(input logic [N-1:0] mask, input logic [IW-1:0] start);
        logic [IW-1:0] pick;
        logic [IW-1:0] idx;
        logic          found;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            idx = IW'((int'(start) + k) % N);
            if (!found && mask[idx]) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return pick;
    endfunction

    always_comb begin
        for (int i = 0; i < N; i++) begin
            w_lane[i] = wdata[i*WIDTH +: WIDTH];
        end
    end

    // The current owner is masked out, so a preempted owner cannot win its own handover.
    assign w_others = req & ~r_gnt;
    assign w_win    = rr_pick(w_others, r_ptr);
    assign w_wr     = r_gnt[r_owner] & wr_en[r_owner];

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        w_hcnt_nxt  = r_hcnt;
        w_do_grant  = 1'b0;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_do_grant = 1'b1;
                end
            end
            BUSY: begin
                if (!req[r_owner]) begin
                    if (|w_others) begin
                        w_do_grant = 1'b1;
                    end else begin
                        w_state_nxt = IDLE;
                        w_gnt_nxt   = '0;
                        w_hcnt_nxt  = '0;
                    end
                end else if ((r_hcnt == HW'(MAX_HOLD)) && (|w_others)) begin
                    w_do_grant = 1'b1;
                end else if (r_hcnt != HW'(MAX_HOLD)) begin
                    w_hcnt_nxt = r_hcnt + HW'(1);
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
        if (w_do_grant) begin
            w_state_nxt = BUSY;
            w_gnt_nxt   = N'(1) << w_win;
            w_owner_nxt = w_win;
            w_ptr_nxt   = (w_win == IW'(N - 1)) ? '0 : w_win + IW'(1);
            w_hcnt_nxt  = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_gnt   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
            r_hcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
            r_hcnt  <= w_hcnt_nxt;
        end
    end

    // Uses the grant held before the edge, so a final-cycle write lands and a new winner's strobe does not.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
        end else if (w_wr) begin
            r_q       <= w_lane[r_owner];
            r_q_valid <= 1'b1;
        end
    end

    assign gnt     = r_gnt;
    assign owner   = r_owner;
    assign busy    = |r_gnt;
    assign q       = r_q;
    assign q_valid = r_q_valid;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// tb/tb_reg_share_arbiter.sv - directed bench with a behavioural ownership model for reg_share_arbiter
module tb_reg_share_arbiter;

    localparam int N        = 4;
    localparam int WIDTH    = 8;
    localparam int MAX_HOLD = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic [N-1:0]         req = '0;
    logic [N-1:0]         wr_en = '0;
    logic [N*WIDTH-1:0]   wdata = '0;
    logic [N-1:0]         gnt;
    logic [1:0]           owner;
    logic                 busy;
    logic [WIDTH-1:0]     q;
    logic                 q_valid;

    int n_vec = 0;
    int n_err = 0;

    reg_share_arbiter #(.N(N), .WIDTH(WIDTH), .MAX_HOLD(MAX_HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .wr_en   (wr_en),
        .wdata   (wdata),
        .gnt     (gnt),
        .owner   (owner),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner is -1 when idle; held counts grant cycles seen so far, capped at MAX_HOLD+1.
    int           m_own  = -1;
    int           m_last = 0;
    int           m_ptr  = 0;
    int           m_held = 0;
    logic [7:0]   m_q    = '0;
    logic         m_qv   = 1'b0;

    task automatic m_grant(input logic [N-1:0] mask);
        for (int k = 0; k < N; k++) begin
            if (mask[(m_ptr + k) % N]) begin
                m_own  = (m_ptr + k) % N;
                m_last = m_own;
                m_ptr  = (m_own + 1) % N;
                m_held = 1;
                break;
            end
        end
    endtask

    always @(posedge clk or negedge rst) begin
        logic [N-1:0] others;
        if (!rst) begin
            m_own = -1; m_last = 0; m_ptr = 0; m_held = 0; m_q = '0; m_qv = 1'b0;
        end else begin
            if (m_own >= 0 && wr_en[m_own]) begin
                m_q  = wdata[m_own*WIDTH +: WIDTH];
                m_qv = 1'b1;
            end
            others = req;
            if (m_own >= 0) others[m_own] = 1'b0;
            if (m_own < 0) begin
                if (req != 0) m_grant(req);
            end else if (!req[m_own]) begin
                if (others != 0) m_grant(others);
                else m_own = -1;
            end else if (m_held > MAX_HOLD && others != 0) begin
                m_grant(others);
            end else if (m_held <= MAX_HOLD) begin
                m_held = m_held + 1;
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] eg;
        eg = (m_own < 0) ? '0 : (N'(1) << m_own);
        chk("model_gnt", 32'(gnt), 32'(eg));
        chk("model_owner", 32'(owner), 32'(m_last));
        chk("model_q", 32'(q), 32'(m_q));
        chk("model_q_valid", 32'(q_valid), 32'(m_qv));
        chk("onehot0_gnt", 32'($onehot0(gnt)), 32'd1);
        chk("busy_eq_or_gnt", 32'(busy), 32'(|gnt));
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; req = '0; wr_en = '0;
        @(negedge clk);
        rst = 1'b1;
    endtask

    logic [N-1:0] pat  [8] = '{4'b1111, 4'b0101, 4'b1010, 4'b0000, 4'b1001, 4'b0110, 4'b1111, 4'b0011};
    logic [N-1:0] wpat [5] = '{4'b1111, 4'b0001, 4'b0000, 4'b1010, 4'b0100};

    initial begin
        // Reset held with noisy inputs
        req = 4'($urandom); wr_en = 4'($urandom); wdata = 32'($urandom);
        repeat (3) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'h0);
            chk("rst_q", 32'(q), 32'h0);
            chk("rst_q_valid", 32'(q_valid), 32'h0);
            chk("rst_busy", 32'(busy), 32'h0);
        end
        req = '0; wr_en = '0; rst = 1'b1;

        // Single requester
        req = 4'b0100; wr_en = 4'b0100; wdata = 32'h00A5_0000;
        @(negedge clk);
        chk("single_gnt", 32'(gnt), 32'h4);
        chk("single_qv_early", 32'(q_valid), 32'h0);
        @(negedge clk);
        chk("single_q", 32'(q), 32'hA5);
        chk("single_qv", 32'(q_valid), 32'h1);
        req = '0; wr_en = '0;
        @(negedge clk);
        chk("single_release", 32'(gnt), 32'h0);

        // Round-robin rotation, each owner holds MAX_HOLD+1 cycles
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 21; c++) begin
            @(negedge clk);
            chk("rr_gnt", 32'(gnt), 32'(1 << (((c - 1) / 5) % 4)));
        end

        // Non-owner write ignored, including at the handover edge
        do_reset();
        req = 4'b0010; wdata = 32'h3C00_7700;
        @(negedge clk);
        chk("nonown_gnt", 32'(gnt), 32'h2);
        wr_en = 4'b1000;
        repeat (3) @(negedge clk);
        chk("nonown_q", 32'(q), 32'h0);
        chk("nonown_qv", 32'(q_valid), 32'h0);
        req = 4'b1010;
        for (int t = 0; t < 10 && gnt !== 4'b1000; t++) @(negedge clk);
        chk("handover_gnt", 32'(gnt), 32'h8);
        chk("handover_q", 32'(q), 32'h0);
        @(negedge clk);
        chk("newowner_q", 32'(q), 32'h3C);

        // Release and final-cycle write at the same edge
        do_reset();
        req = 4'b0001; wr_en = '0;
        @(negedge clk);
        chk("sim_gnt0", 32'(gnt), 32'h1);
        req = 4'b0100; wr_en = 4'b0001; wdata = 32'h00EE_0011;
        @(negedge clk);
        chk("sim_q", 32'(q), 32'h11);
        chk("sim_gnt", 32'(gnt), 32'h4);
        chk("sim_owner", 32'(owner), 32'h2);

        // Lone hog, then preemption once another requester appears
        do_reset();
        req = 4'b0010; wr_en = '0;
        repeat (20) begin
            @(negedge clk);
            chk("hog_gnt", 32'(gnt), 32'h2);
        end
        req = 4'b1010;
        @(negedge clk);
        chk("hog_preempt", 32'(gnt), 32'h8);
        chk("hog_owner", 32'(owner), 32'h3);
        wr_en = 4'b1000; wdata = 32'h5A00_0000;
        @(negedge clk);
        chk("hog_q", 32'(q), 32'h5A);

        // Asynchronous reset mid-grant
        #2 rst = 1'b0;
        #1;
        chk("arst_gnt", 32'(gnt), 32'h0);
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_q", 32'(q), 32'h0);
        chk("arst_qv", 32'(q_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1; req = '0; wr_en = '0;

        // Directed pattern table, checked by the model each cycle
        for (int i = 0; i < 96; i++) begin
            req   = pat[(i / 6) % 8];
            wr_en = wpat[i % 5];
            wdata = 32'(i) * 32'h0101_0101 + 32'h3020_1000;
            @(negedge clk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

endmodule
